// File: rtl/aes_cipher_iter.sv
// Iterative AES-128 encryption core: UNROLL chained rounds per clock, 10/UNROLL clocks per block.
// Defining AES_ITER_KEY_REUSE_EN adds a key_reuse input that replays the previously loaded key.
module aes_cipher_iter #(
  parameter int UNROLL = 1,
  parameter int LENGTH = 128
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LENGTH-1:0] key,
  input  logic [LENGTH-1:0] usr_text,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LENGTH-1:0] enc_text,
  output logic              busy
`ifdef AES_ITER_KEY_REUSE_EN
  ,
  input  logic              key_reuse
`endif
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : gBadUnroll
    $error("aes_cipher_iter: UNROLL must be 1, 2, 5 or 10");
  end
  if (LENGTH != 128) begin : gBadLength
    $error("aes_cipher_iter: LENGTH must be 128");
  end

  // Byte 0 of a block sits in element [15], i.e. bits [127:120].
  typedef logic [15:0][7:0] blockT;
  typedef enum logic [1:0] {IDLE, RUN, DONE} fsmT;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [2047:0] shifted;
    shifted = SBOX << {b, 3'b000};
    return shifted[2047:2040];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd0: return 8'h01;
      4'd1: return 8'h02;
      4'd2: return 8'h04;
      4'd3: return 8'h08;
      4'd4: return 8'h10;
      4'd5: return 8'h20;
      4'd6: return 8'h40;
      4'd7: return 8'h80;
      4'd8: return 8'h1b;
      4'd9: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic blockT subBytes(input blockT b);
    return {sbox(b[15]), sbox(b[14]), sbox(b[13]), sbox(b[12]),
            sbox(b[11]), sbox(b[10]), sbox(b[9]),  sbox(b[8]),
            sbox(b[7]),  sbox(b[6]),  sbox(b[5]),  sbox(b[4]),
            sbox(b[3]),  sbox(b[2]),  sbox(b[1]),  sbox(b[0])};
  endfunction

  function automatic blockT shiftRows(input blockT b);
    return {b[15], b[10], b[5],  b[0],
            b[11], b[6],  b[1],  b[12],
            b[7],  b[2],  b[13], b[8],
            b[3],  b[14], b[9],  b[4]};
  endfunction

  function automatic logic [31:0] mixColumn(input logic [3:0][7:0] a);
    return {xtime(a[3]) ^ xtime(a[2]) ^ a[2] ^ a[1] ^ a[0],
            a[3] ^ xtime(a[2]) ^ xtime(a[1]) ^ a[1] ^ a[0],
            a[3] ^ a[2] ^ xtime(a[1]) ^ xtime(a[0]) ^ a[0],
            xtime(a[3]) ^ a[3] ^ a[2] ^ a[1] ^ xtime(a[0])};
  endfunction

  function automatic blockT mixColumns(input blockT b);
    return {mixColumn(b[15:12]), mixColumn(b[11:8]), mixColumn(b[7:4]), mixColumn(b[3:0])};
  endfunction

  // Produces the round r+1 key from the round r key.
  function automatic blockT keyExpand(input blockT k, input logic [3:0] r);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {sbox(k[2]), sbox(k[1]), sbox(k[0]), sbox(k[3])};
    w0 = k[15:12] ^ t ^ {rcon(r), 24'h000000};
    w1 = k[11:8] ^ w0;
    w2 = k[7:4] ^ w1;
    w3 = k[3:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  fsmT        fsm;
  blockT      stateReg, rkey, nextState, nextKey, effKey, firstKey;
  logic [3:0] rnd, nextRnd;
  logic       accept;

  assign in_ready = (fsm == IDLE) || (fsm == DONE && out_ready);
  assign accept   = in_valid && in_ready;

`ifdef AES_ITER_KEY_REUSE_EN
  blockT keyHold;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      keyHold <= '0;
    else if (accept && !key_reuse)
      keyHold <= key;
  end

  assign effKey = key_reuse ? keyHold : blockT'(key);
`else
  assign effKey = key;
`endif

  assign firstKey = keyExpand(effKey, 4'd0);

  // Round 10 skips MixColumns; UNROLL always divides 10, so the chain never passes round 10.
  always_comb begin
    blockT      s, k;
    logic [3:0] r;
    s = stateReg;
    k = rkey;
    r = rnd;
    for (int i = 0; i < UNROLL; i++) begin
      s = shiftRows(subBytes(s));
      if (r != 4'd10) s = mixColumns(s);
      s = s ^ k;
      k = keyExpand(k, r);
      r = r + 4'd1;
    end
    nextState = s;
    nextKey   = k;
    nextRnd   = r;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fsm       <= IDLE;
      stateReg  <= '0;
      rkey      <= '0;
      rnd       <= '0;
      enc_text  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (accept) begin
      stateReg  <= usr_text ^ effKey;
      rkey      <= firstKey;
      rnd       <= 4'd1;
      fsm       <= RUN;
      out_valid <= 1'b0;
      busy      <= 1'b1;
    end else begin
      case (fsm)
        RUN: begin
          stateReg <= nextState;
          rkey     <= nextKey;
          rnd      <= nextRnd;
          if (nextRnd == 4'd11) begin
            enc_text  <= nextState;
            fsm       <= DONE;
            out_valid <= 1'b1;
            busy      <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm       <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Scoreboard bench for aes_cipher_iter using FIPS-197 vectors; UNROLL=1 main instance plus 2/5/10 instances.
// Exercises the key reuse path when AES_ITER_KEY_REUSE_EN is defined.
module tb_aes_cipher_iter;

  localparam logic [127:0] K0 = 128'h0;
  localparam logic [127:0] P0 = 128'h0;
  localparam logic [127:0] C0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [127:0] key = '0;
  logic [127:0] usr_text = '0;
  logic         in_ready, out_valid, busy;
  logic [127:0] enc_text;
`ifdef AES_ITER_KEY_REUSE_EN
  logic         keyReuse = 1'b0;
`endif

  logic         auxValid = 1'b0;
  logic [2:0]   auxInReady, auxOutValid, auxBusy;
  logic [127:0] auxEnc [3];
  int           auxU [3] = '{2, 5, 10};

  logic [127:0] expQ [$];
  int           total = 0;
  int           bad = 0;

  always #5 clk = ~clk;

  aes_cipher_iter #(.UNROLL(1)) dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready),
    .key(key), .usr_text(usr_text), .out_valid(out_valid), .out_ready(out_ready),
    .enc_text(enc_text), .busy(busy)
`ifdef AES_ITER_KEY_REUSE_EN
    , .key_reuse(keyReuse)
`endif
  );

  for (genvar g = 0; g < 3; g++) begin : gAux
    aes_cipher_iter #(.UNROLL(g == 0 ? 2 : (g == 1 ? 5 : 10))) dutAux (
      .clk(clk), .nrst(nrst), .in_valid(auxValid), .in_ready(auxInReady[g]),
      .key(K2), .usr_text(P2), .out_valid(auxOutValid[g]), .out_ready(1'b1),
      .enc_text(auxEnc[g]), .busy(auxBusy[g])
`ifdef AES_ITER_KEY_REUSE_EN
      , .key_reuse(1'b0)
`endif
    );
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents one block, waits (bounded) for in_ready, and records the expected ciphertext.
  task automatic applyStimulus(input logic [127:0] k, input logic [127:0] t, input logic [127:0] e);
    int n = 0;
    in_valid = 1'b1;
    key      = k;
    usr_text = t;
    while (!in_ready && n < 50) begin
      tick;
      n++;
    end
    checkOutput("inReadyWait", 128'(in_ready), 128'(1));
    expQ.push_back(e);
    tick;
    in_valid = 1'b0;
  endtask

  task automatic waitResult(input int expLat, input string tag, input bit scramble);
    int n = 0;
    logic [127:0] e;
    while (!out_valid && n < 40) begin
      if (scramble) begin
        key      = {$urandom, $urandom, $urandom, $urandom};
        usr_text = {$urandom, $urandom, $urandom, $urandom};
      end
      tick;
      n++;
    end
    checkOutput({tag, "Lat"}, 128'(n), 128'(expLat));
    e = (expQ.size() != 0) ? expQ.pop_front() : 'x;
    checkOutput({tag, "Text"}, enc_text, e);
    checkOutput({tag, "Busy"}, 128'(busy), 128'(0));
  endtask

  initial begin
    bit seen [3];
    logic [127:0] e;
    $display("[TB] aes_cipher_iter bench start");

    tick;
    tick;
    checkOutput("rstOutValid", 128'(out_valid), 128'(0));
    checkOutput("rstBusy", 128'(busy), 128'(0));
    checkOutput("rstEnc", enc_text, 128'(0));
    nrst = 1'b1;
    tick;
    checkOutput("rstInReady", 128'(in_ready), 128'(1));

    // One FIPS-197 appendix B block into the UNROLL=2/5/10 instances at once.
    auxValid = 1'b1;
    repeat (3) expQ.push_back(C2);
    tick;
    auxValid = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      tick;
      for (int g = 0; g < 3; g++) begin
        if (!seen[g] && auxOutValid[g]) begin
          seen[g] = 1'b1;
          checkOutput($sformatf("aux%0dLat", auxU[g]), 128'(n), 128'(10 / auxU[g]));
          e = (expQ.size() != 0) ? expQ.pop_front() : 'x;
          checkOutput($sformatf("aux%0dText", auxU[g]), auxEnc[g], e);
        end
      end
    end
    for (int g = 0; g < 3; g++)
      checkOutput($sformatf("aux%0dSeen", auxU[g]), 128'(seen[g]), 128'(1));

    out_ready = 1'b1;
    applyStimulus(K1, P1, C1);
    checkOutput("runBusy", 128'(busy), 128'(1));
    checkOutput("runInReady", 128'(in_ready), 128'(0));
    waitResult(10, "basic", 1'b0);
    tick;
    checkOutput("consumedValid", 128'(out_valid), 128'(0));
    checkOutput("retainEnc", enc_text, C1);
    checkOutput("idleInReady", 128'(in_ready), 128'(1));

    out_ready = 1'b0;
    applyStimulus(K2, P2, C2);
    waitResult(10, "bp", 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick;
      checkOutput("bpValid", 128'(out_valid), 128'(1));
      checkOutput("bpEnc", enc_text, C2);
      checkOutput("bpInReady", 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    applyStimulus(K0, P0, C0);
    checkOutput("bpDrop", 128'(out_valid), 128'(0));
    checkOutput("bpRunBusy", 128'(busy), 128'(1));
    waitResult(10, "chain", 1'b0);
    tick;

    applyStimulus(K1, P1, C1);
    waitResult(10, "iso", 1'b1);
    tick;

    applyStimulus(K2, P2, C2);
    repeat (3) tick;
    checkOutput("midBusy", 128'(busy), 128'(1));
    #1 nrst = 1'b0;
    #1;
    checkOutput("midRstValid", 128'(out_valid), 128'(0));
    checkOutput("midRstBusy", 128'(busy), 128'(0));
    checkOutput("midRstEnc", enc_text, 128'(0));
    expQ.delete();
    #1 nrst = 1'b1;
    tick;
    checkOutput("postRstInReady", 128'(in_ready), 128'(1));
    applyStimulus(K0, P0, C0);
    waitResult(10, "postRst", 1'b0);
    tick;

`ifdef AES_ITER_KEY_REUSE_EN
    keyReuse = 1'b0;
    applyStimulus(K2, P2, C2);
    waitResult(10, "reuseLoad", 1'b0);
    tick;
    keyReuse = 1'b1;
    applyStimulus(128'h0, P2, C2);
    waitResult(10, "reuse", 1'b0);
    tick;
    keyReuse = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
